// File: rtl/db_io_scheduler.sv
// Issue stage for the double-buffered core: strobes/data registered 1 cycle after handshake.
// Backpressure: in_ready drops once the frame write budget is spent; reads gated until the priming frame is full.
module db_io_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [CNT_WIDTH-1:0]  depth,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  rd_req,
  output logic                  wen_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ren_out,
  output logic [CNT_WIDTH-1:0]  count_wen,
  output logic [CNT_WIDTH-1:0]  count_ren,
  output logic                  switch_pulse,
  output logic                  cfg_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PRIME  = 2'd1;
  localparam logic [1:0] S_STEADY = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_WIDTH-1:0]  r_depth_q;
  logic [CNT_WIDTH-1:0]  r_count_wen;
  logic [CNT_WIDTH-1:0]  r_count_ren;
  logic                  r_wen;
  logic                  r_ren;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_switch;
  logic                  r_cfg_err;

  logic                  w_active;
  logic                  w_in_ready;
  logic                  w_wacc;
  logic                  w_racc;
  logic [CNT_WIDTH-1:0]  w_wen_nxt;
  logic [CNT_WIDTH-1:0]  w_ren_nxt;
  logic                  w_rollover;

  assign w_active   = (r_state == S_PRIME) || (r_state == S_STEADY);
  assign w_in_ready = w_active && (r_count_wen < r_depth_q);
  assign w_wacc     = in_valid && w_in_ready;
  assign w_racc     = rd_req && (r_state == S_STEADY) && (r_count_ren < r_depth_q);

  // Acceptance gating keeps both counters at or below depth_q, so these never wrap.
  assign w_wen_nxt = r_count_wen + CNT_WIDTH'(w_wacc);
  assign w_ren_nxt = r_count_ren + CNT_WIDTH'(w_racc);

  always_comb begin
    w_rollover = 1'b0;
    if (r_state == S_PRIME)
      w_rollover = w_wacc && (w_wen_nxt == r_depth_q);
    else if (r_state == S_STEADY)
      w_rollover = (w_wacc || w_racc) && (w_wen_nxt == r_depth_q) && (w_ren_nxt == r_depth_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_depth_q   <= '0;
      r_count_wen <= '0;
      r_count_ren <= '0;
      r_wen       <= 1'b0;
      r_ren       <= 1'b0;
      r_data      <= '0;
      r_switch    <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else if (clk_en) begin
      r_wen    <= w_wacc;
      r_ren    <= w_racc;
      r_switch <= 1'b0;
      if (w_wacc)
        r_data <= in_data;
      case (r_state)
        S_IDLE: begin
          r_count_wen <= '0;
          r_count_ren <= '0;
          if (in_valid && !flush) begin
            r_depth_q <= depth;
            if (depth == '0)
              r_cfg_err <= 1'b1;
            else
              r_state <= S_PRIME;
          end
        end
        S_PRIME, S_STEADY: begin
          // flush wins over a same-cycle rollover and drops the strobes it would have issued
          if (flush) begin
            r_state     <= S_IDLE;
            r_count_wen <= '0;
            r_count_ren <= '0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
          end else if (w_rollover) begin
            r_state     <= S_STEADY;
            r_count_wen <= '0;
            r_count_ren <= '0;
            r_switch    <= 1'b1;
          end else begin
            r_count_wen <= w_wen_nxt;
            r_count_ren <= w_ren_nxt;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_count_wen <= '0;
          r_count_ren <= '0;
        end
      endcase
    end else begin
      r_switch <= 1'b0;
    end
  end

  assign in_ready     = w_in_ready;
  assign wen_out      = r_wen;
  assign ren_out      = r_ren;
  assign data_out     = r_data;
  assign count_wen    = r_count_wen;
  assign count_ren    = r_count_ren;
  assign switch_pulse = r_switch && clk_en;
  assign cfg_err      = r_cfg_err;

endmodule

// File: doc/db_io_scheduler.md
Name: db_io_scheduler

Overview:
- Upstream issue stage for the double-buffered memory core.
- Turns a valid/ready input stream and a downstream read-request line into per-cycle write-enable/data and read-enable strobes for the core.
- Enforces per-frame bounds: at most depth writes and depth reads per frame.
- Handles the initial priming frame and the frame switch, so the core never sees an out-of-bounds or early read.

Parameters:
- DATA_WIDTH, 16, width of the data path.
- CNT_WIDTH, 16, width of depth and of the per-frame counters.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- clk_en  input  1  clock enable; when low, all state holds.
- flush  input  1  synchronous abort of the current frame; returns to IDLE.
- depth  input  CNT_WIDTH  frame size; sampled on leaving IDLE.
- in_valid  input  1  upstream data valid.
- in_data  input  DATA_WIDTH  upstream data.
- in_ready  output  1  scheduler accepts in_data this cycle.
- rd_req  input  1  downstream requests one read.
- wen_out  output  1  write strobe to the core.
- data_out  output  DATA_WIDTH  write data to the core.
- ren_out  output  1  read strobe to the core.
- count_wen  output  CNT_WIDTH  writes issued in the current frame.
- count_ren  output  CNT_WIDTH  reads issued in the current frame.
- switch_pulse  output  1  one-cycle pulse at frame rollover.
- cfg_err  output  1  sticky flag: depth==0 was sampled.

Behaviour:
- Reset (async): state=IDLE; in_ready, wen_out, ren_out, switch_pulse, cfg_err = 0; data_out, count_wen, count_ren = 0; depth_q=0.
- Gating: all updates require clk_en=1. When clk_en=0, outputs hold except switch_pulse, which is forced to 0.
- Registered outputs: wen_out, data_out and ren_out are registered, one cycle after the accepted handshake.
- Write accept: wacc = in_valid & in_ready.
  - in_ready = (state is PRIME or STEADY) & (count_wen < depth_q). It is combinational from state and counters.
- Read accept: racc = rd_req & (state==STEADY) & (count_ren < depth_q).
  - rd_req is ignored in PRIME; no read occurs before one full frame is written.
- Invariant: count_ren + depth_q >= count_wen, and both counters are <= depth_q, at all times.
- States:
  - IDLE: leave when in_valid=1 and flush=0.
    - Latch depth_q=depth.
    - If depth==0: set cfg_err and stay in IDLE.
    - Otherwise go to PRIME with counters at 0.
  - PRIME: writes only. When count_wen reaches depth_q: zero both counters, pulse switch_pulse, go to STEADY.
  - STEADY: writes and reads run concurrently. Rollover happens when the frame completes (count_wen==depth_q and count_ren==depth_q after this cycle's increments). Completion covers three cases:
    - last write and last read in the same cycle;
    - last read when writes are already done;
    - last write when reads are already done.
  - On rollover: both counters go to 0 in that cycle, switch_pulse=1 for one cycle, state stays STEADY.
- Same-cycle increments: wacc and racc in the same cycle both increment. Counters never exceed depth_q; acceptance gating guarantees this.
- depth changes: changes outside IDLE are ignored (depth_q is held).
- flush:
  - Next cycle: state=IDLE; counters=0; wen_out=ren_out=0.
  - No switch_pulse is generated.
  - cfg_err is not cleared; only reset clears it.
  - flush has priority over a same-cycle rollover.
- Reset mid-frame: all state clears immediately and asynchronously. In-flight strobes are dropped.
- Arithmetic: compare with CNT_WIDTH unsigned. The sum count_ren+depth_q is evaluated at CNT_WIDTH+1 bits to avoid wrap.

Test Plan:
- Prime frame: depth=4, in_valid held 1, rd_req=1 → 4 wen_out pulses on cycles 2-5, ren_out stays 0, switch_pulse on the 4th accept, count_wen returns to 0.
- Concurrent steady: depth=4, in_valid=rd_req=1 in STEADY → wen_out and ren_out asserted on the same cycles. Both counters reach 4 together, then both reset to 0 with one switch_pulse.
- Asymmetric finish: depth=3; 3 writes, rd_req low, then 3 reads → in_ready=0 after the 3rd write. Rollover happens on the 3rd read only.
- Bound hold: depth=2, rd_req=0 in STEADY, in_valid=1 for 10 cycles → exactly 2 writes, count_wen=2, in_ready=0, no switch_pulse.
- Config error and flush:
  - depth=0 with in_valid=1 → cfg_err=1, state stays IDLE, no wen_out.
  - flush at count_wen=1 (depth=4) → counters 0, IDLE next cycle, no switch_pulse.
- clk_en and reset:
  - clk_en=0 for 3 cycles mid-frame → counters and outputs frozen.
  - reset asserted between clock edges → all outputs 0 before the next edge.
